// File: rtl/music_pkg.sv
// Shared types and constants for the tune sequencer: pitch divider table, FSM states and
// the layout of a note word in the tune RAM.
package music_pkg;

  localparam int unsigned NUM_SEMITONES = 12;
  localparam int unsigned WORD_W        = 8;
  localparam int unsigned CODE_W        = 6;
  localparam int unsigned DIV_W         = 9;

  // Note word fields
  localparam int unsigned END_BIT   = 7;
  localparam int unsigned SPARE_BIT = 6;
  localparam int unsigned CODE_MSB  = 5;
  localparam int unsigned CODE_LSB  = 0;

  // Semitone dividers, index 0 = A up to index 11 = G#
  localparam logic [NUM_SEMITONES-1:0][DIV_W-1:0] DIV_TABLE = {
    9'd270, 9'd286, 9'd303, 9'd322, 9'd341, 9'd361,
    9'd383, 9'd405, 9'd430, 9'd455, 9'd482, 9'd511
  };

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StPlay
  } state_e;

  function automatic logic [DIV_W-1:0] div_of(input logic [3:0] semitone);
    return (semitone < 4'd12) ? DIV_TABLE[semitone] : DIV_TABLE[0];
  endfunction

endpackage

// File: rtl/pitch_gen.sv
// Note code to square wave: a prescaler of (255>>octave)+1 cycles feeds a semitone divider of
// DIV+1 ticks, so the output flips every (DIV+1)*((255>>octave)+1) cycles.
module pitch_gen
  import music_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] code,
  input  logic              restart,
  input  logic              enable,
  output logic              speaker
);

  logic [2:0]       octave;
  logic [3:0]       semitone;
  logic [7:0]       pre_last;
  logic [DIV_W-1:0] div_last;
  logic             run;

  logic [7:0]       pre_q, pre_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             spk_q, spk_d;

  always_comb begin
    octave   = 3'(code / CODE_W'(12));
    semitone = 4'(code % CODE_W'(12));
    pre_last = 8'hff >> octave;
    div_last = div_of(semitone);
    // Code 0 is a rest; counters stay clear so the next note starts in phase.
    run      = enable && !restart && (code != '0);
  end

  always_comb begin
    pre_d = '0;
    div_d = '0;
    spk_d = 1'b0;
    if (run) begin
      pre_d = pre_q + 8'd1;
      div_d = div_q;
      spk_d = spk_q;
      if (pre_q == pre_last) begin
        pre_d = '0;
        if (div_q == div_last) begin
          div_d = '0;
          spk_d = ~spk_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      div_q <= '0;
      spk_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      div_q <= div_d;
      spk_q <= spk_d;
    end
  end

  assign speaker = spk_q & run;

endmodule

// File: rtl/tune_sequencer.sv
// Tune sequencer: plays a writable RAM of note words at a fixed tempo onto a square-wave pin.
// Define ARTICULATION_EN to silence the last 1/16 of every step so repeated notes separate.
module tune_sequencer
  import music_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned STEP_CYCLES = 20971520,
  parameter int unsigned STEP_W      = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_en,
  output logic              speaker,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] step_addr
);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  logic [WORD_W-1:0] ram [DEPTH];
  logic [WORD_W-1:0] rd_q;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              rd_en, step_end, tone_en;
  logic              unused_spare;

  // Read is issued on the edge entering FETCH, so the word is valid throughout FETCH and
  // stays put while the step plays.
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= wr_data;
    if (rd_en) rd_q <= ram[addr_d];
  end

  assign unused_spare = rd_q[SPARE_BIT];

  assign step_end = (state_q == StPlay) && (cnt_q == STEP_LAST);
  assign cnt_d    = (state_q == StPlay && !step_end) ? cnt_q + STEP_W'(1) : '0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (play) begin
            state_d = StFetch;
            addr_d  = '0;
          end
        end
        StFetch: begin
          if (!rd_q[END_BIT]) begin
            state_d = StPlay;
          end else if (loop_en && addr_q != '0) begin
            addr_d = '0;
          end else begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        StPlay: begin
          if (step_end) begin
            if (addr_q == ADDR_LAST && !loop_en) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              state_d = StFetch;
              addr_d  = addr_q + ADDR_W'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign rd_en = (state_d == StFetch);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

`ifdef ARTICULATION_EN
  localparam logic [STEP_W-1:0] GAP_START = STEP_W'(STEP_CYCLES - STEP_CYCLES / 16);
  assign tone_en = (state_q == StPlay) && (cnt_q < GAP_START);
`else
  assign tone_en = (state_q == StPlay);
`endif

  pitch_gen u_pitch_gen (
    .clk    (clk),
    .reset  (reset),
    .code   (rd_q[CODE_MSB:CODE_LSB]),
    .restart(state_q == StFetch),
    .enable (tone_en),
    .speaker(speaker)
  );

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign step_addr = addr_q;

endmodule

// File: tb/tb_tune_sequencer.sv
// Bench for tune_sequencer: a step/position model predicts every output each cycle; directed
// tunes pin the model with literal timings, then randomized tunes run against it.
module tb_tune_sequencer;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;
  localparam int STEP   = 4800;  // shortened tempo keeps the run small; 4800/16 = 300
  localparam int STEP_W = 13;
`ifdef ARTICULATION_EN
  localparam int GAP = STEP / 16;
`else
  localparam int GAP = 0;
`endif

  logic              clk = 1'b0;
  logic              reset, wr_en, play, stop, loop_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              speaker, busy, done;
  logic [ADDR_W-1:0] step_addr;

  always #5 clk = ~clk;

  tune_sequencer #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .STEP_CYCLES(STEP),
    .STEP_W     (STEP_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .play     (play),
    .stop     (stop),
    .loop_en  (loop_en),
    .speaker  (speaker),
    .busy     (busy),
    .done     (done),
    .step_addr(step_addr)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Model: playback position within the current step, and the tune RAM image.
  bit         m_busy = 0, m_fetch = 0, m_done = 0;
  int         m_addr = 0, m_pos = 0;
  logic [7:0] m_word = 0;
  logic [5:0] m_code = 0;
  logic [7:0] m_mem [DEPTH];

  function automatic int half_period(input int code);
    int divs [12] = '{511, 482, 455, 430, 405, 383, 361, 341, 322, 303, 286, 270};
    return (divs[code % 12] + 1) * ((255 >> (code / 12)) + 1);
  endfunction

  function automatic bit exp_speaker();
    if (!m_busy || m_fetch || m_code == 0 || m_pos >= STEP - GAP) return 1'b0;
    return ((m_pos / half_period(int'(m_code))) % 2) == 1;
  endfunction

  always @(posedge clk) begin
    m_done = 0;
    if (reset) begin
      m_busy = 0; m_fetch = 0; m_addr = 0;
    end else if (stop) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (play) begin
        m_busy = 1; m_fetch = 1; m_addr = 0; m_word = m_mem[0];
      end
    end else if (m_fetch) begin
      if (m_word[7]) begin
        if (loop_en && m_addr != 0) begin
          m_addr = 0; m_word = m_mem[0];
        end else begin
          m_busy = 0; m_done = 1;
        end
      end else begin
        m_fetch = 0; m_pos = 0; m_code = m_word[5:0];
      end
    end else if (m_pos == STEP - 1) begin
      if (m_addr == DEPTH - 1 && !loop_en) begin
        m_busy = 0; m_done = 1;
      end else begin
        m_addr = (m_addr + 1) % DEPTH; m_fetch = 1; m_word = m_mem[m_addr];
      end
    end else begin
      m_pos++;
    end
    if (wr_en) m_mem[wr_addr] = wr_data;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("speaker", speaker, exp_speaker());
      if (m_busy) check("step_addr", step_addr, m_addr);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input int a, input int d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = 8'(d);
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic start();
    play = 1'b1;
    tick(1);
    check("lit_busy_after_play", busy, 1);
    play = 1'b0;
  endtask

  task automatic window(input int n, output int dones, output int ones, output int idles);
    dones = 0; ones = 0; idles = 0;
    repeat (n) begin
      tick(1);
      dones += int'(done); ones += int'(speaker); idles += int'(!busy);
    end
  endtask

  initial begin
    int d, o, i, r, w;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    play = 1'b0; stop = 1'b0; loop_en = 1'b0;
    tick(2);
    chk_en = 1;
    check("lit_reset_busy", busy, 0);
    check("lit_reset_speaker", speaker, 0);
    check("lit_reset_done", done, 0);
    check("lit_reset_addr", step_addr, 0);
    reset = 1'b0;

    // Code 60 then end marker: half-period 4096, one done pulse
    write(0, 60); write(1, 8'h80);
    start();
    tick(4096); check("lit_c60_before_toggle", speaker, 0);
    tick(1);    check("lit_c60_toggle", speaker, 1);
    window(STEP - 4096 + 20, d, o, i);
    check("lit_c60_done_count", d, 1);
    check("lit_c60_busy_end", busy, 0);

    // Code 63, rest, marker: half-period 3448, rest step silent
    write(0, 63); write(1, 0); write(2, 8'h80);
    start();
    tick(3448); check("lit_c63_before_toggle", speaker, 0);
    tick(1);    check("lit_c63_toggle", speaker, 1);
    tick(1052); check("lit_c63_tail", speaker, (GAP != 0) ? 0 : 1);
    tick(301);  check("lit_rest_addr", step_addr, 1);
    window(STEP, d, o, i);
    check("lit_rest_silent", o, 0);
    window(10, d, o, i);
    check("lit_rest_done_count", d, 1);

    // Loop: marker at step 1 sends playback back to step 0
    write(0, 60); write(1, 8'h80);
    loop_en = 1'b1;
    start();
    tick(STEP); check("lit_loop_addr0", step_addr, 0);
    tick(1);    check("lit_loop_addr1", step_addr, 1);
    tick(1);    check("lit_loop_back", step_addr, 0);
    window(STEP / 2, d, o, i);
    check("lit_loop_no_done", d, 0);
    check("lit_loop_busy", i, 0);
    stop = 1'b1; tick(1); stop = 1'b0; loop_en = 1'b0;
    check("lit_loop_stopped", busy, 0);

    // Stop and play together mid-note: stop wins
    write(0, 63); write(1, 8'h80);
    start();
    tick(4001); check("lit_stop_sounding", speaker, 1);
    stop = 1'b1; play = 1'b1;
    tick(1);
    stop = 1'b0; play = 1'b0;
    check("lit_stop_busy", busy, 0);
    check("lit_stop_speaker", speaker, 0);
    check("lit_stop_done", done, 0);
    tick(3); check("lit_stop_stays_idle", busy, 0);

    // Overwrite step 1 while step 0 plays, then reset mid-step
    write(0, 60); write(1, 50); write(2, 8'h80);
    start();
    tick(1000); write(1, 63);
    tick(3801); check("lit_ovw_addr", step_addr, 1);
    tick(3447); check("lit_ovw_before_toggle", speaker, 0);
    tick(1);    check("lit_ovw_toggle", speaker, 1);
    tick(100);
    reset = 1'b1; tick(1); reset = 1'b0;
    check("lit_rst_busy", busy, 0);
    check("lit_rst_speaker", speaker, 0);
    check("lit_rst_done", done, 0);
    check("lit_rst_addr", step_addr, 0);

    // No marker: tune ends on expiry of the last RAM step
    write(0, 55); write(1, 0); write(2, 60); write(3, 62);
    start();
    tick(3 * (STEP + 1) + 1); check("lit_last_addr", step_addr, DEPTH - 1);
    window(STEP + 5, d, o, i);
    check("lit_last_done_count", d, 1);
    check("lit_last_busy", busy, 0);

    // Randomized tunes with stray stop/play/write traffic
    for (int run = 0; run < 2; run++) begin
      for (int a = 0; a < DEPTH; a++) begin
        r = int'($urandom_range(0, 9));
        if (r == 0) w = 8'h80;
        else if (r == 1) w = 0;
        else w = int'($urandom_range(40, 63)) | (int'($urandom_range(0, 1)) << 6);
        write(a, w);
      end
      loop_en = 1'($urandom_range(0, 1));
      start();
      for (int k = 0; k < STEP * 3 / 2; k++) begin
        stop    = ($urandom_range(0, 3999) == 0);
        play    = ($urandom_range(0, 499) == 0);
        wr_en   = ($urandom_range(0, 999) == 0);
        wr_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        wr_data = 8'($urandom_range(0, 255));
        tick(1);
      end
      stop = 1'b1; play = 1'b0; wr_en = 1'b0;
      tick(1);
      stop = 1'b0; loop_en = 1'b0;
    end

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
